// File: rtl/apb2axi_fifo_sync.sv
// rtl/apb2axi_fifo_sync.sv - single-clock first-word-fall-through FIFO with occupancy flags
// Optional high-water-mark output max_cnt is built only when APB2AXI_FIFO_STATS_EN is defined.
module apb2axi_fifo_sync #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_rdy,
  output logic [CNT_W-1:0] word_cnt,
  output logic             almost_empty,
  output logic             almost_full
`ifdef APB2AXI_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0] max_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  // Ready/valid depend only on registered occupancy, so a pop never frees a slot same-cycle.
  assign wr_rdy       = (cnt_q != FULL_CNT);
  assign rd_vld       = (cnt_q != '0);
  assign rd_data      = mem_q[rd_ptr_q];
  assign word_cnt     = cnt_q;
  assign almost_empty = (int'(cnt_q) <= AE_LEVEL);
  assign almost_full  = (int'(cnt_q) >= AF_LEVEL);

  assign push = wr_vld & wr_rdy & ~flush;
  assign pop  = rd_vld & rd_rdy & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately unreset; rd_vld masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef APB2AXI_FIFO_STATS_EN
  logic [CNT_W-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (flush)              max_d = '0;
    else if (cnt_q > max_q) max_d = cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) max_q <= '0;
    else         max_q <= max_d;
  end

  assign max_cnt = max_q;
`endif

endmodule

// File: tb/tb_apb2axi_fifo_sync.sv
// tb/tb_apb2axi_fifo_sync.sv - directed table and sequence checks for apb2axi_fifo_sync
module tb_apb2axi_fifo_sync;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic       wv, rr, w5v, r5;
  logic [7:0] wd, w5d;
  logic       wrdy, rvld, ae, af, wrdy5, rvld5, ae5, af5;
  logic [7:0] rdat, rdat5;
  logic [4:0] cnt;
  logic [2:0] cnt5;
`ifdef APB2AXI_FIFO_STATS_EN
  logic [4:0] maxc;
  logic [2:0] maxc5;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb2axi_fifo_sync #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .wr_vld(wv), .wr_data(wd), .wr_rdy(wrdy),
    .rd_vld(rvld), .rd_data(rdat), .rd_rdy(rr),
    .word_cnt(cnt), .almost_empty(ae), .almost_full(af)
`ifdef APB2AXI_FIFO_STATS_EN
    , .max_cnt(maxc)
`endif
  );

  apb2axi_fifo_sync #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .resetn(resetn), .flush(1'b0),
    .wr_vld(w5v), .wr_data(w5d), .wr_rdy(wrdy5),
    .rd_vld(rvld5), .rd_data(rdat5), .rd_rdy(r5),
    .word_cnt(cnt5), .almost_empty(ae5), .almost_full(af5)
`ifdef APB2AXI_FIFO_STATS_EN
    , .max_cnt(maxc5)
`endif
  );

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic [4:0] cnt;
    logic       wrdy;
    logic       rvld;
    logic       chkd;
    logic [7:0] rdat;
    logic       ae;
    logic       af;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r, input int c,
                              input logic cd, input logic [7:0] hd);
    vec_t t;
    t.wv = v; t.wd = d; t.rr = r;
    t.cnt  = 5'(c);
    t.wrdy = (c != 16);
    t.rvld = (c != 0);
    t.chkd = cd;
    t.rdat = hd;
    t.ae   = (c <= 1);
    t.af   = (c >= 15);
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = mk(1'b1, 8'(8'hA0 + i), 1'b0, i + 1, 1'b1, 8'hA0);
    for (int k = 0; k < 16; k++)
      tbl[16+k] = mk(1'b0, 8'h00, 1'b1, 15 - k, (k != 15), 8'(8'hA0 + k + 1));

    resetn = 1'b0; flush = 1'b0;
    wv = 1'b0; wd = '0; rr = 1'b0; w5v = 1'b0; w5d = '0; r5 = 1'b0;
    #1;
    chk("rst cnt", cnt, 0);
    chk("rst wr_rdy", wrdy, 1);
    chk("rst rd_vld", rvld, 0);
    chk("rst ae", ae, 1);
    chk("rst af", af, 0);
    chk("rst5 cnt", cnt5, 0);
`ifdef APB2AXI_FIFO_STATS_EN
    chk("rst max", maxc, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    // fill to full then drain, DEPTH=16
    for (int i = 0; i < 32; i++) begin
      wv = tbl[i].wv; wd = tbl[i].wd; rr = tbl[i].rr;
      step();
      chk($sformatf("v%0d cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("v%0d wr_rdy", i), wrdy, tbl[i].wrdy);
      chk($sformatf("v%0d rd_vld", i), rvld, tbl[i].rvld);
      chk($sformatf("v%0d ae", i), ae, tbl[i].ae);
      chk($sformatf("v%0d af", i), af, tbl[i].af);
      if (tbl[i].chkd) chk($sformatf("v%0d rd_data", i), rdat, tbl[i].rdat);
    end
    wv = 1'b0; rr = 1'b0;

    // full with simultaneous write and read: pop only
    for (int i = 0; i < 16; i++) begin
      wv = 1'b1; wd = 8'(8'hC0 + i);
      step();
    end
    wd = 8'hEE;
    step();
    chk("full blocked cnt", cnt, 16);
    chk("full blocked head", rdat, 8'hC0);
    rr = 1'b1;
    step();
    chk("full rw cnt", cnt, 15);
    chk("full rw head", rdat, 8'hC1);
    chk("full rw wr_rdy", wrdy, 1);
    rr = 1'b0;
    step();
    chk("refill cnt", cnt, 16);
    wv = 1'b0; flush = 1'b1;
    step();
    chk("flush1 cnt", cnt, 0);
    flush = 1'b0;

    // flush overrides a same-cycle write
    for (int i = 0; i < 7; i++) begin
      wv = 1'b1; wd = 8'(8'hD0 + i);
      step();
    end
    chk("pre flush cnt", cnt, 7);
    flush = 1'b1; wd = 8'h77;
    step();
    chk("flush cnt", cnt, 0);
    chk("flush rd_vld", rvld, 0);
`ifdef APB2AXI_FIFO_STATS_EN
    chk("flush max", maxc, 0);
`endif
    flush = 1'b0; wd = 8'h55;
    step();
    chk("post flush cnt", cnt, 1);
    chk("post flush head", rdat, 8'h55);
    wv = 1'b0;
    step();
`ifdef APB2AXI_FIFO_STATS_EN
    chk("post flush max", maxc, 1);
`endif

    // asynchronous reset between edges at word_cnt=9
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wv = 1'b1; wd = 8'(8'h90 + i);
      step();
    end
    wv = 1'b0;
    chk("pre rst cnt", cnt, 9);
    #2 resetn = 1'b0;
    #1;
    chk("async cnt", cnt, 0);
    chk("async wr_rdy", wrdy, 1);
    chk("async rd_vld", rvld, 0);
    chk("async ae", ae, 1);
    @(negedge clk) resetn = 1'b1;
    wv = 1'b1; wd = 8'h3C;
    step();
    wv = 1'b0;
    chk("after rst cnt", cnt, 1);
    chk("after rst head", rdat, 8'h3C);

    // DEPTH=5 steady push+pop across pointer wrap
    for (int i = 0; i < 3; i++) begin
      w5v = 1'b1; w5d = 8'(8'h10 + i);
      step();
    end
    chk("d5 preload cnt", cnt5, 3);
    r5 = 1'b1;
    for (int k = 0; k < 23; k++) begin
      chk($sformatf("d5 head%0d", k), rdat5, 8'(8'h10 + k));
      w5d = 8'(8'h13 + k);
      step();
      chk($sformatf("d5 cnt%0d", k), cnt5, 3);
    end
    w5v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d5 tail%0d", k), rdat5, 8'(8'h27 + k));
      step();
    end
    r5 = 1'b0;
    chk("d5 empty rd_vld", rvld5, 0);
    chk("d5 empty ae", ae5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
